wbu_commit_arb: RTL and testbench
=================================

Name: wbu_commit_arb

Overview:
- Completion-side counterpart of the long-instruction hazard unit.
- Collects results from the integer long-latency units (MUL, DIV, CSR, LSU), each tagged with the commit ID that the hazard unit allocated.
- Arbitrates round-robin onto the single integer register-file write port.
- Emits the one-cycle commit_valid/commit_id pulse that frees the matching hazard FIFO entry.

Parameters:
- NUM_SRC, 4, number of completion sources; index 0=MUL, 1=DIV, 2=CSR, 3=LSU.
- BUF_DEPTH, 2, entries per source skid buffer (only used with WBU_SKID_BUF_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- src_valid_i  in  NUM_SRC  per-source completion valid
- src_ready_o  out  NUM_SRC  per-source completion accepted
- src_commit_id_i  in  NUM_SRC*`COMMIT_ID_WIDTH  packed commit IDs; source i at slice i
- src_rd_we_i  in  NUM_SRC  source result writes rd
- src_rd_addr_i  in  NUM_SRC*`REG_ADDR_WIDTH  packed destination registers
- src_rd_data_i  in  NUM_SRC*`REG_DATA_WIDTH  packed result data
- reg_we_o  out  1  register-file write enable
- reg_waddr_o  out  `REG_ADDR_WIDTH  write address
- reg_wdata_o  out  `REG_DATA_WIDTH  write data
- commit_valid_o  out  1  to hazard unit commit_valid_int_i
- commit_id_o  out  `COMMIT_ID_WIDTH  to hazard unit commit_id_int_i
- busy_o  out  1  any source holding an unretired completion

Behaviour:
- Handshake: a transfer occurs when src_valid_i[i] && src_ready_o[i] on a rising edge.
  - Source i must hold valid and all payload stable until it is accepted.
  - src_valid_i must not depend combinationally on src_ready_o.
- Candidates: the head of each source (buffer head, or the live input when the buffer is compiled out).
- Arbiter: round-robin pointer rr_ptr, range 0..NUM_SRC-1.
  - Grant goes to the first requesting candidate at index rr_ptr, rr_ptr+1, ... with wrap-around.
  - After a grant to g, rr_ptr <= (g+1) mod NUM_SRC.
  - rr_ptr is unchanged when nothing is granted.
- Output stage: registered; one grant per cycle; latency 1 cycle from grant to outputs.
  - Cycle after a grant: commit_valid_o=1 and commit_id_o = granted ID for exactly one cycle.
  - Same cycle: reg_we_o = granted rd_we && (rd_addr != 0), with reg_waddr_o and reg_wdata_o taken from the granted entry.
  - No downstream backpressure: the hazard unit and register file always accept.
- Writes to x0: the register write is suppressed, but the commit pulse is still issued.
- Without a grant: commit_valid_o=0 and reg_we_o=0. commit_id_o, reg_waddr_o and reg_wdata_o are driven 0.
- busy_o: OR of all buffer non-empty flags and all src_valid_i.
- Reset (rst=1 at an edge):
  - All outputs registered 0, rr_ptr=0, all buffers emptied.
  - A reset mid-operation discards buffered completions with no commit pulse; the hazard unit is reset in the same cycle.
- Simultaneous completions from all sources are serialised in round-robin order, one commit per cycle.
- Sustained throughput: 1 commit per cycle whenever any candidate is pending.
- Duplicate IDs are never presented concurrently by construction (the hazard unit allocates unique IDs); no checking is done.

Optional Feature:
- Macro: WBU_SKID_BUF_EN.
- Defined:
  - Each source gets a BUF_DEPTH-entry FIFO holding {commit_id, rd_we, rd_addr, rd_data}.
  - src_ready_o[i] = (count_i < BUF_DEPTH), derived only from registered state; no valid-to-ready combinational path.
  - Push and grant-pop in the same cycle are allowed; count is unchanged.
  - Full: ready=0; a push is ignored until a pop.
  - The pointer wraps modulo BUF_DEPTH.
  - Minimum accept-to-commit latency: 2 cycles (enqueue, then arbitrate).
- Undefined:
  - No storage; src_ready_o[i] = grant[i], combinational from src_valid_i and rr_ptr.
  - Accept-to-commit latency: 1 cycle.

Test Plan:
- Reset, then MUL only: valid, id=3, rd=5, data=0x1234 -> next cycle commit_valid_o=1, commit_id_o=3, reg_we_o=1, waddr=5, wdata=0x1234; the following cycle all pulses are 0.
- All four sources valid in the same cycle, ids 1,2,4,6, rr_ptr=0 -> commits on 4 consecutive cycles with ids 1,2,4,6; rr_ptr ends at 0.
- rr_ptr=2 with DIV and LSU both valid -> LSU (id of source 3) commits first, then DIV; rr_ptr=2 afterwards.
- CSR completion with rd=0, id=7 -> commit_valid_o=1, commit_id_o=7, reg_we_o=0.
- With WBU_SKID_BUF_EN: hold MUL valid for 3 back-to-back pushes while DIV continuously wins an alternating grant -> MUL ready drops after 2 entries; all 3 MUL IDs commit in order with no loss.
- Assert rst while two buffered entries are pending -> no commit pulse afterwards, busy_o=0 and src_ready_o all 1 (buffer mode) on the cycle after reset.

Source files
------------

// File: rtl/wbu_commit_arb.sv
// wbu_commit_arb: collects completions from the long-latency integer units
// (0=MUL, 1=DIV, 2=CSR, 3=LSU). It grants one per cycle, round-robin, onto
// the single register-file write port and pulses commit_valid/commit_id to
// free the matching hazard-unit entry.
// Optional build macro WBU_SKID_BUF_EN: adds a BUF_DEPTH-entry FIFO per
// source, so ready depends only on registered fill state. Without it, ready
// is the grant itself and there is no storage.

`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module wbu_commit_arb #(
  parameter int NUM_SRC   = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_SRC-1:0]                    src_valid_i,
  output logic [NUM_SRC-1:0]                    src_ready_o,
  input  logic [NUM_SRC*`COMMIT_ID_WIDTH-1:0]   src_commit_id_i,
  input  logic [NUM_SRC-1:0]                    src_rd_we_i,
  input  logic [NUM_SRC*`REG_ADDR_WIDTH-1:0]    src_rd_addr_i,
  input  logic [NUM_SRC*`REG_DATA_WIDTH-1:0]    src_rd_data_i,
  output logic                                  reg_we_o,
  output logic [`REG_ADDR_WIDTH-1:0]            reg_waddr_o,
  output logic [`REG_DATA_WIDTH-1:0]            reg_wdata_o,
  output logic                                  commit_valid_o,
  output logic [`COMMIT_ID_WIDTH-1:0]           commit_id_o,
  output logic                                  busy_o
);

  localparam int IDW   = `COMMIT_ID_WIDTH;
  localparam int AW    = `REG_ADDR_WIDTH;
  localparam int DW    = `REG_DATA_WIDTH;
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] cand_valid;
  logic [IDW-1:0]     cand_id   [NUM_SRC];
  logic               cand_we   [NUM_SRC];
  logic [AW-1:0]      cand_addr [NUM_SRC];
  logic [DW-1:0]      cand_data [NUM_SRC];

  logic [NUM_SRC-1:0] grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  int                 arb_idx;
  logic [PTR_W-1:0]   arb_sel;

  logic               commit_valid_q, commit_valid_d;
  logic [IDW-1:0]     commit_id_q, commit_id_d;
  logic               reg_we_q, reg_we_d;
  logic [AW-1:0]      reg_waddr_q, reg_waddr_d;
  logic [DW-1:0]      reg_wdata_q, reg_wdata_d;

`ifdef WBU_SKID_BUF_EN
  localparam int BPTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);

  logic [IDW-1:0]    buf_id_q   [NUM_SRC][BUF_DEPTH];
  logic              buf_we_q   [NUM_SRC][BUF_DEPTH];
  logic [AW-1:0]     buf_addr_q [NUM_SRC][BUF_DEPTH];
  logic [DW-1:0]     buf_data_q [NUM_SRC][BUF_DEPTH];
  logic [BPTR_W-1:0] wr_ptr_q [NUM_SRC];
  logic [BPTR_W-1:0] rd_ptr_q [NUM_SRC];
  logic [CNT_W-1:0]  count_q  [NUM_SRC];
  logic [NUM_SRC-1:0] push;

  function automatic logic [BPTR_W-1:0] ptr_inc(input logic [BPTR_W-1:0] p);
    return (p == BPTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready and candidates come from registered FIFO state only
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready_o[i] = (count_q[i] < CNT_W'(BUF_DEPTH));
      push[i]        = src_valid_i[i] && src_ready_o[i];
      cand_valid[i]  = (count_q[i] != '0);
      cand_id[i]     = buf_id_q[i][rd_ptr_q[i]];
      cand_we[i]     = buf_we_q[i][rd_ptr_q[i]];
      cand_addr[i]   = buf_addr_q[i][rd_ptr_q[i]];
      cand_data[i]   = buf_data_q[i][rd_ptr_q[i]];
    end
    busy_o = (|src_valid_i) || (|cand_valid);
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        buf_id_q[i][wr_ptr_q[i]]   <= src_commit_id_i[i*IDW +: IDW];
        buf_we_q[i][wr_ptr_q[i]]   <= src_rd_we_i[i];
        buf_addr_q[i][wr_ptr_q[i]] <= src_rd_addr_i[i*AW +: AW];
        buf_data_q[i][wr_ptr_q[i]] <= src_rd_data_i[i*DW +: DW];
      end
    end
  end

  // FIFO pointers and fill counts; push and pop together leave count unchanged
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end else begin
        if (push[i])  wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
        if (grant[i]) rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
        if (push[i] && !grant[i])      count_q[i] <= count_q[i] + 1'b1;
        else if (!push[i] && grant[i]) count_q[i] <= count_q[i] - 1'b1;
      end
    end
  end
`else
  // Pass-through: the live input is the candidate and ready is the grant
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cand_valid[i] = src_valid_i[i];
      cand_id[i]    = src_commit_id_i[i*IDW +: IDW];
      cand_we[i]    = src_rd_we_i[i];
      cand_addr[i]  = src_rd_addr_i[i*AW +: AW];
      cand_data[i]  = src_rd_data_i[i*DW +: DW];
    end
    src_ready_o = grant;
    busy_o      = |src_valid_i;
  end
`endif

  // Round-robin search starting at rr_ptr, plus next-state of the output stage
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    arb_idx = 0;
    arb_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      arb_idx = int'(rr_ptr_q) + k;
      if (arb_idx >= NUM_SRC) arb_idx = arb_idx - NUM_SRC;
      arb_sel = PTR_W'(arb_idx);
      if (!gnt_any && cand_valid[arb_sel]) begin
        gnt_any = 1'b1;
        gnt_idx = arb_sel;
      end
    end
    grant[gnt_idx] = gnt_any;

    rr_ptr_d = rr_ptr_q;
    if (gnt_any) rr_ptr_d = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;

    commit_valid_d = gnt_any;
    commit_id_d    = gnt_any ? cand_id[gnt_idx] : '0;
    reg_we_d       = gnt_any && cand_we[gnt_idx] && (cand_addr[gnt_idx] != '0);
    reg_waddr_d    = gnt_any ? cand_addr[gnt_idx] : '0;
    reg_wdata_d    = gnt_any ? cand_data[gnt_idx] : '0;
  end

  // Registered output stage and arbitration pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      reg_we_q       <= 1'b0;
      reg_waddr_q    <= '0;
      reg_wdata_q    <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
      reg_we_q       <= reg_we_d;
      reg_waddr_q    <= reg_waddr_d;
      reg_wdata_q    <= reg_wdata_d;
    end
  end

  assign commit_valid_o = commit_valid_q;
  assign commit_id_o    = commit_id_q;
  assign reg_we_o       = reg_we_q;
  assign reg_waddr_o    = reg_waddr_q;
  assign reg_wdata_o    = reg_wdata_q;

endmodule

// File: tb/tb_wbu_commit_arb.sv
// Directed bench for wbu_commit_arb: round-robin order, x0 suppression,
// reset discard, and (with WBU_SKID_BUF_EN) buffer fill/backpressure.

`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module tb_wbu_commit_arb;
  localparam int N   = 4;
  localparam int IDW = `COMMIT_ID_WIDTH;
  localparam int AW  = `REG_ADDR_WIDTH;
  localparam int DW  = `REG_DATA_WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      src_valid;
  logic [N-1:0]      src_ready;
  logic [N*IDW-1:0]  src_id;
  logic [N-1:0]      src_we;
  logic [N*AW-1:0]   src_addr;
  logic [N*DW-1:0]   src_data;
  logic              reg_we;
  logic [AW-1:0]     reg_waddr;
  logic [DW-1:0]     reg_wdata;
  logic              commit_valid;
  logic [IDW-1:0]    commit_id;
  logic              busy;

  int checks = 0;
  int errors = 0;

  wbu_commit_arb #(.NUM_SRC(N), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_commit_id_i(src_id), .src_rd_we_i(src_we),
    .src_rd_addr_i(src_addr), .src_rd_data_i(src_data),
    .reg_we_o(reg_we), .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata),
    .commit_valid_o(commit_valid), .commit_id_o(commit_id), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic cv, input int id,
                         input logic we, input int wa, input logic [DW-1:0] wd);
    chk({tag, ".commit_valid"}, 64'(commit_valid), 64'(cv));
    chk({tag, ".commit_id"},    64'(commit_id),    64'(id));
    chk({tag, ".reg_we"},       64'(reg_we),       64'(we));
    chk({tag, ".reg_waddr"},    64'(reg_waddr),    64'(wa));
    chk({tag, ".reg_wdata"},    64'(reg_wdata),    64'(wd));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input int id, input logic we,
                         input int addr, input logic [DW-1:0] data);
    src_valid[i]            = 1'b1;
    src_id[i*IDW +: IDW]    = IDW'(id);
    src_we[i]               = we;
    src_addr[i*AW +: AW]    = AW'(addr);
    src_data[i*DW +: DW]    = data;
  endtask

  task automatic clr_src(input int i);
    src_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    src_valid = '0; src_id = '0; src_we = '0; src_addr = '0; src_data = '0;
    do_reset();

    chk_out("reset", 1'b0, 0, 1'b0, 0, '0);
    chk("reset.busy", 64'(busy), 64'(0));
`ifdef WBU_SKID_BUF_EN
    chk("reset.ready", 64'(src_ready), 64'hF);

    // Single MUL completion: enqueue, then arbitrate -> 2-cycle latency
    set_src(0, 3, 1'b1, 5, 32'h1234);
    #1 chk("buf_mul.ready", 64'(src_ready), 64'hF);
    step(); clr_src(0);
    chk("buf_mul.no_commit_yet", 64'(commit_valid), 64'(0));
    chk("buf_mul.busy", 64'(busy), 64'(1));
    step();
    chk_out("buf_mul.commit", 1'b1, 3, 1'b1, 5, 32'h1234);
    step();
    chk_out("buf_mul.idle", 1'b0, 0, 1'b0, 0, '0);
    chk("buf_mul.busy_after", 64'(busy), 64'(0));

    // MUL pushes ids 1..4 while DIV pushes 11..14; grants alternate MUL/DIV
    do_reset();
    begin
      int mul_id [10] = '{1, 2, 3, 4, 4, 0, 0, 0, 0, 0};
      int div_id [10] = '{11, 12, 13, 13, 14, 14, 0, 0, 0, 0};
      logic [3:0] rdy [10] = '{4'hF, 4'hF, 4'hD, 4'hE, 4'hD, 4'hE, 4'hD, 4'hF, 4'hF, 4'hF};
      int cm [10] = '{0, 1, 11, 2, 12, 3, 13, 4, 14, 0};
      for (int c = 0; c < 10; c++) begin
        if (mul_id[c] != 0) set_src(0, mul_id[c], 1'b1, mul_id[c], DW'(mul_id[c])); else clr_src(0);
        if (div_id[c] != 0) set_src(1, div_id[c], 1'b1, div_id[c], DW'(div_id[c])); else clr_src(1);
        #1 chk($sformatf("skid.ready[%0d]", c), 64'(src_ready), 64'(rdy[c]));
        step();
        if (cm[c] != 0) chk_out($sformatf("skid.commit[%0d]", c), 1'b1, cm[c], 1'b1, cm[c], DW'(cm[c]));
        else chk($sformatf("skid.nocommit[%0d]", c), 64'(commit_valid), 64'(0));
      end
    end

    // Reset while two entries are buffered discards them silently
    do_reset();
    set_src(0, 5, 1'b1, 7, 32'h55);
    set_src(1, 6, 1'b1, 8, 32'h66);
    step();
    clr_src(0); clr_src(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("bufrst.commit_valid", 64'(commit_valid), 64'(0));
    chk("bufrst.busy", 64'(busy), 64'(0));
    chk("bufrst.ready", 64'(src_ready), 64'hF);
    step();
    chk("bufrst.commit_after", 64'(commit_valid), 64'(0));
    chk("bufrst.busy_after", 64'(busy), 64'(0));
`else
    chk("reset.ready", 64'(src_ready), 64'h0);

    // MUL only: commit visible the cycle after acceptance, one cycle only
    set_src(0, 3, 1'b1, 5, 32'h1234);
    #1 chk("mul.ready", 64'(src_ready), 64'h1);
    chk("mul.busy", 64'(busy), 64'(1));
    step(); clr_src(0);
    chk_out("mul.commit", 1'b1, 3, 1'b1, 5, 32'h1234);
    step();
    chk_out("mul.idle", 1'b0, 0, 1'b0, 0, '0);

    // All four at once from rr_ptr=0: ids 1,2,4,6 in source order
    do_reset();
    begin
      int ids [4] = '{1, 2, 4, 6};
      for (int k = 0; k < 4; k++) set_src(k, ids[k], 1'b1, k + 1, DW'(32'hA0 + k));
      for (int k = 0; k < 4; k++) begin
        #1 chk($sformatf("all4.ready[%0d]", k), 64'(src_ready), 64'(1 << k));
        step(); clr_src(k);
        chk_out($sformatf("all4.commit[%0d]", k), 1'b1, ids[k], 1'b1, k + 1, DW'(32'hA0 + k));
      end
    end
    step();
    chk("all4.idle", 64'(commit_valid), 64'(0));

    // DIV alone moves rr_ptr to 2; then DIV+LSU -> LSU first, then DIV
    set_src(1, 5, 1'b1, 10, 32'h10);
    #1 chk("div.ready", 64'(src_ready), 64'h2);
    step(); clr_src(1);
    chk_out("div.commit", 1'b1, 5, 1'b1, 10, 32'h10);
    set_src(1, 8, 1'b1, 11, 32'h11);
    set_src(3, 9, 1'b1, 12, 32'h12);
    #1 chk("rr2.ready_lsu", 64'(src_ready), 64'h8);
    step(); clr_src(3);
    chk_out("rr2.commit_lsu", 1'b1, 9, 1'b1, 12, 32'h12);
    chk("rr2.ready_div", 64'(src_ready), 64'h2);
    step(); clr_src(1);
    chk_out("rr2.commit_div", 1'b1, 8, 1'b1, 11, 32'h11);

    // rr_ptr back at 2: CSR (rd=x0) beats MUL; x0 write suppressed, commit kept
    set_src(2, 7, 1'b1, 0, 32'hDEAD);
    set_src(0, 10, 1'b1, 3, 32'h33);
    #1 chk("x0.ready_csr", 64'(src_ready), 64'h4);
    step(); clr_src(2);
    chk_out("x0.commit", 1'b1, 7, 1'b0, 0, 32'hDEAD);
    chk("x0.ready_mul", 64'(src_ready), 64'h1);
    step(); clr_src(0);
    chk_out("x0.mul_commit", 1'b1, 10, 1'b1, 3, 32'h33);

    // Result without rd write: commit pulse only
    set_src(3, 12, 1'b0, 9, 32'h99);
    step(); clr_src(3);
    chk("nowe.commit_valid", 64'(commit_valid), 64'(1));
    chk("nowe.commit_id", 64'(commit_id), 64'(12));
    chk("nowe.reg_we", 64'(reg_we), 64'(0));
    step();
    chk_out("nowe.idle", 1'b0, 0, 1'b0, 0, '0);

    // Reset coinciding with a pending completion yields no pulse
    set_src(0, 4, 1'b1, 6, 32'hAA);
    rst = 1'b1;
    step();
    clr_src(0);
    rst = 1'b0;
    chk("rst.commit_valid", 64'(commit_valid), 64'(0));
    chk("rst.reg_we", 64'(reg_we), 64'(0));
    #1 chk("rst.busy", 64'(busy), 64'(0));
    step();
    chk("rst.commit_after", 64'(commit_valid), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
